// File: rtl/baser_block_lock_ctrl.sv
// Receive-side 10GBASE-R block-lock controller (clk_156 domain).
// Watches the 2-bit sync header of each 66b block, pulses slip to the gearbox/aligner until
// header alignment is found, then tracks header error rate (hi_ber) and a debounced link_up.
//
// Ports:
//   clk_156    - PCS clock, 156.25 MHz
//   rst_156    - asynchronous active-low reset
//   enable     - controller run; low holds the controller in init with outputs cleared
//   sh_en      - sh is valid this cycle (one strobe per 66b block)
//   sh         - sync header; 2'b01 / 2'b10 valid, 2'b00 / 2'b11 invalid
//   slip       - one-cycle pulse asking the aligner to shift by one bit
//   block_lock - header alignment achieved
//   hi_ber     - high bit-error-rate condition
//   link_up    - debounced receive link status
//   slip_cnt   - saturating count of slip pulses since reset or enable rise
module baser_block_lock_ctrl #(
  parameter int unsigned SH_CNT_LOCK    = 64,
  parameter int unsigned SH_CNT_MAX     = 1024,
  parameter int unsigned SH_INVLD_MAX   = 65,
  parameter int unsigned SLIP_WAIT_CYC  = 32,
  parameter int unsigned BER_WINDOW_CYC = 19531,
  parameter int unsigned BER_THRESH     = 16,
  parameter int unsigned LINK_HOLD_CYC  = 1024
) (
  input  logic        clk_156,
  input  logic        rst_156,
  input  logic        enable,
  input  logic        sh_en,
  input  logic [1:0]  sh,
  output logic        slip,
  output logic        block_lock,
  output logic        hi_ber,
  output logic        link_up,
  output logic [15:0] slip_cnt
);

  localparam int unsigned ShCntLim = (SH_CNT_MAX > SH_CNT_LOCK) ? SH_CNT_MAX : SH_CNT_LOCK;
  localparam int unsigned ShCntW   = $clog2(ShCntLim) + 1;
  localparam int unsigned InvW     = $clog2(SH_INVLD_MAX) + 1;
  localparam int unsigned WaitW    = $clog2(SLIP_WAIT_CYC) + 1;
  localparam int unsigned WinW     = $clog2(BER_WINDOW_CYC) + 1;
  localparam int unsigned BerW     = $clog2(BER_THRESH) + 1;
  localparam int unsigned HoldW    = $clog2(LINK_HOLD_CYC) + 1;

  localparam logic [ShCntW-1:0] ShCntLockC = ShCntW'(SH_CNT_LOCK);
  localparam logic [ShCntW-1:0] ShCntMaxC  = ShCntW'(SH_CNT_MAX);
  localparam logic [InvW-1:0]   InvMaxC    = InvW'(SH_INVLD_MAX);
  localparam logic [WaitW-1:0]  WaitLastC  = WaitW'(SLIP_WAIT_CYC - 1);
  localparam logic [WinW-1:0]   WinLastC   = WinW'(BER_WINDOW_CYC - 1);
  localparam logic [BerW-1:0]   BerThreshC = BerW'(BER_THRESH);
  localparam logic [HoldW-1:0]  HoldC      = HoldW'(LINK_HOLD_CYC);

  typedef enum logic [1:0] {StInit, StTest, StSlip, StSlipWait} state_e;

  state_e            state_q, state_d;
  logic [ShCntW-1:0] sh_cnt_q, sh_cnt_d, sh_cnt_inc;
  logic [InvW-1:0]   invld_q, invld_d, invld_inc;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [WinW-1:0]   win_q, win_d;
  logic [BerW-1:0]   ber_q, ber_d, ber_base;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [15:0]       slip_cnt_q, slip_cnt_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  logic              hi_ber_q, hi_ber_d;
  logic              link_q, link_d;
  logic              sh_bad, goto_slip, win_end, ber_hit, cond_q, cond_d;

  assign sh_bad     = (sh == 2'b00) || (sh == 2'b11);
  assign sh_cnt_inc = sh_cnt_q + ShCntW'(1);
  assign invld_inc  = invld_q + InvW'(sh_bad);

  // Block-lock state machine.
  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    invld_d    = invld_q;
    wait_d     = wait_q;
    lock_d     = lock_q;
    slip_d     = 1'b0;
    slip_cnt_d = slip_cnt_q;
    goto_slip  = 1'b0;
    if (!enable) begin
      state_d    = StInit;
      sh_cnt_d   = '0;
      invld_d    = '0;
      wait_d     = '0;
      lock_d     = 1'b0;
      slip_cnt_d = '0;
    end else begin
      unique case (state_q)
        StInit: begin
          sh_cnt_d = '0;
          invld_d  = '0;
          wait_d   = '0;
          lock_d   = 1'b0;
          state_d  = StTest;
        end
        StTest: begin
          if (sh_en) begin
            if (!lock_q) begin
              if (sh_bad) begin
                goto_slip = 1'b1;
              end else if (sh_cnt_inc == ShCntLockC) begin
                lock_d   = 1'b1;
                sh_cnt_d = '0;
                invld_d  = '0;
              end else begin
                sh_cnt_d = sh_cnt_inc;
              end
            end else begin
              // Loss of lock wins over the window-end clear.
              if (invld_inc == InvMaxC) begin
                lock_d    = 1'b0;
                goto_slip = 1'b1;
              end else if (sh_cnt_inc == ShCntMaxC) begin
                sh_cnt_d = '0;
                invld_d  = '0;
              end else begin
                sh_cnt_d = sh_cnt_inc;
                invld_d  = invld_inc;
              end
            end
            if (goto_slip) begin
              state_d    = StSlip;
              slip_d     = 1'b1;
              slip_cnt_d = (slip_cnt_q == 16'hFFFF) ? slip_cnt_q : slip_cnt_q + 16'd1;
              sh_cnt_d   = '0;
              invld_d    = '0;
            end
          end
        end
        StSlip: begin
          sh_cnt_d = '0;
          invld_d  = '0;
          wait_d   = '0;
          lock_d   = 1'b0;
          state_d  = StSlipWait;
        end
        StSlipWait: begin
          // Aligner settle time: sh_en is ignored here.
          if (wait_q == WaitLastC) begin
            wait_d  = '0;
            state_d = StTest;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  // hi_ber window and link_up debounce; both follow the next-state lock so they drop together.
  assign win_end = lock_q && (win_q == WinLastC);
  assign ber_hit = lock_q && sh_en && sh_bad;
  assign cond_q  = lock_q && !hi_ber_q;

  always_comb begin
    win_d    = '0;
    ber_d    = '0;
    hi_ber_d = 1'b0;
    // An error on the window-end cycle lands in the new window.
    ber_base = win_end ? '0 : ber_q;
    if (lock_q && lock_d) begin
      win_d = win_end ? '0 : win_q + WinW'(1);
      ber_d = ber_base;
      if (ber_hit && (ber_base != BerThreshC)) begin
        ber_d = ber_base + BerW'(1);
      end
      if (win_end) begin
        hi_ber_d = (ber_q == BerThreshC) || (ber_d == BerThreshC);
      end else begin
        hi_ber_d = hi_ber_q || (ber_d == BerThreshC);
      end
    end
  end

  assign cond_d = lock_d && !hi_ber_d;

  always_comb begin
    hold_d = '0;
    if (cond_d) begin
      hold_d = (cond_q && (hold_q != HoldC)) ? hold_q + HoldW'(1) : hold_q;
    end
    link_d = cond_d && (hold_d == HoldC);
  end

  always_ff @(posedge clk_156 or negedge rst_156) begin
    if (!rst_156) begin
      state_q    <= StInit;
      sh_cnt_q   <= '0;
      invld_q    <= '0;
      wait_q     <= '0;
      win_q      <= '0;
      ber_q      <= '0;
      hold_q     <= '0;
      slip_cnt_q <= '0;
      lock_q     <= 1'b0;
      slip_q     <= 1'b0;
      hi_ber_q   <= 1'b0;
      link_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      invld_q    <= invld_d;
      wait_q     <= wait_d;
      win_q      <= win_d;
      ber_q      <= ber_d;
      hold_q     <= hold_d;
      slip_cnt_q <= slip_cnt_d;
      lock_q     <= lock_d;
      slip_q     <= slip_d;
      hi_ber_q   <= hi_ber_d;
      link_q     <= link_d;
    end
  end

  assign slip       = slip_q;
  assign block_lock = lock_q;
  assign hi_ber     = hi_ber_q;
  assign link_up    = link_q;
  assign slip_cnt   = slip_cnt_q;

endmodule

// File: tb/tb_baser_block_lock_ctrl.sv
// Directed testbench for baser_block_lock_ctrl (BER window shortened to 200 cycles).
module tb_baser_block_lock_ctrl;

  logic        clk_156 = 1'b0;
  logic        rst_156 = 1'b0;
  logic        enable  = 1'b0;
  logic        sh_en   = 1'b0;
  logic [1:0]  sh      = 2'b01;
  logic        slip;
  logic        block_lock;
  logic        hi_ber;
  logic        link_up;
  logic [15:0] slip_cnt;

  int passed = 0;
  int total  = 0;
  int cyc_n = 0;
  int lock_cyc = 0;
  int slip_seen = 0;
  int last_slip = -1;
  int min_gap = 0;
  int max_gap = 0;
  logic prev_lock = 1'b0;

  baser_block_lock_ctrl #(
    .SH_CNT_LOCK   (64),
    .SH_CNT_MAX    (1024),
    .SH_INVLD_MAX  (65),
    .SLIP_WAIT_CYC (32),
    .BER_WINDOW_CYC(200),
    .BER_THRESH    (16),
    .LINK_HOLD_CYC (1024)
  ) dut (
    .clk_156   (clk_156),
    .rst_156   (rst_156),
    .enable    (enable),
    .sh_en     (sh_en),
    .sh        (sh),
    .slip      (slip),
    .block_lock(block_lock),
    .hi_ber    (hi_ber),
    .link_up   (link_up),
    .slip_cnt  (slip_cnt)
  );

  always #5 clk_156 = ~clk_156;

  // One clock: drive, take the edge, sample 1 ns later, track slip pulses and lock rise.
  task automatic tick(input logic en, input logic [1:0] hv);
    sh_en = en;
    sh    = hv;
    @(posedge clk_156);
    cyc_n++;
    #1;
    if (slip) begin
      slip_seen++;
      if (last_slip >= 0) begin
        if (min_gap == 0 || cyc_n - last_slip < min_gap) min_gap = cyc_n - last_slip;
        if (cyc_n - last_slip > max_gap) max_gap = cyc_n - last_slip;
      end
      last_slip = cyc_n;
    end
    if (block_lock && !prev_lock) lock_cyc = cyc_n;
    prev_lock = block_lock;
    sh_en = 1'b0;
  endtask

  // From the SLIP state: 1 + 32 ignored cycles, then 64 valid headers.
  task automatic relock();
    for (int i = 0; i < 97; i++) tick(1'b1, 2'b10);
  endtask

  // Run until tgt cycles after lock; headers on odd cycles, invalid on odd cycles in [lo,hi]
  // and on cycle ex.
  task automatic run_to(input int tgt, input int lo, input int hi, input int ex);
    int nk;
    logic en, bad;
    for (int g = 0; g < 5000 && (cyc_n - lock_cyc) < tgt; g++) begin
      nk  = cyc_n - lock_cyc + 1;
      en  = (nk % 2 == 1) || (nk == ex);
      bad = (nk == ex) || (nk >= lo && nk <= hi && nk % 2 == 1);
      tick(en, bad ? 2'b11 : 2'b01);
    end
  endtask

  task automatic test_reset();
    rst_156 = 1'b0;
    enable  = 1'b0;
    repeat (2) @(posedge clk_156);
    #1;
    total++; if (slip !== 1'b0) $display("FAIL rst_slip: got %b want 0", slip); else passed++;
    total++; if (block_lock !== 1'b0) $display("FAIL rst_lock: got %b want 0", block_lock);
    else passed++;
    total++; if (hi_ber !== 1'b0) $display("FAIL rst_hiber: got %b want 0", hi_ber); else passed++;
    total++; if (link_up !== 1'b0) $display("FAIL rst_link: got %b want 0", link_up); else passed++;
    total++; if (slip_cnt !== 16'd0) $display("FAIL rst_slipcnt: got %0d want 0", slip_cnt);
    else passed++;
    rst_156 = 1'b1;
  endtask

  task automatic test_lock();
    enable = 1'b1;
    tick(1'b0, 2'b01);
    for (int i = 0; i < 63; i++) begin
      tick(1'b1, 2'b01);
      tick(1'b0, 2'b01);
    end
    total++; if (block_lock !== 1'b0) $display("FAIL lock_63: got %b want 0", block_lock);
    else passed++;
    tick(1'b1, 2'b10);
    total++; if (block_lock !== 1'b1) $display("FAIL lock_64: got %b want 1", block_lock);
    else passed++;
    total++; if (slip_seen !== 0) $display("FAIL lock_noslip: got %0d pulses want 0", slip_seen);
    else passed++;
    total++; if (slip_cnt !== 16'd0) $display("FAIL lock_slipcnt: got %0d want 0", slip_cnt);
    else passed++;
    run_to(1023, 1, 0, -1);
    total++; if (link_up !== 1'b0) $display("FAIL link_1023: got %b want 0", link_up);
    else passed++;
    run_to(1024, 1, 0, -1);
    total++; if (link_up !== 1'b1) $display("FAIL link_1024: got %b want 1", link_up);
    else passed++;
  endtask

  task automatic test_slip();
    enable = 1'b0;
    tick(1'b0, 2'b01);
    total++; if (block_lock !== 1'b0) $display("FAIL en_lock_drop: got %b want 0", block_lock);
    else passed++;
    total++; if (link_up !== 1'b0) $display("FAIL en_link_drop: got %b want 0", link_up);
    else passed++;
    enable = 1'b1;
    tick(1'b0, 2'b01);
    slip_seen = 0;
    last_slip = -1;
    min_gap   = 0;
    max_gap   = 0;
    for (int g = 0; g < 400 && slip_seen < 5; g++) tick(1'b1, 2'b11);
    total++; if (slip_seen !== 5) $display("FAIL slip_pulses: got %0d want 5", slip_seen);
    else passed++;
    total++; if (slip !== 1'b1) $display("FAIL slip_fifth: got %b want 1", slip); else passed++;
    total++; if (slip_cnt !== 16'd5) $display("FAIL slip_cnt5: got %0d want 5", slip_cnt);
    else passed++;
    total++; if (min_gap !== 34 || max_gap !== 34)
      $display("FAIL slip_gap: got min %0d max %0d want 34", min_gap, max_gap);
    else passed++;
    for (int i = 0; i < 96; i++) tick(1'b1, 2'b01);
    total++; if (block_lock !== 1'b0) $display("FAIL slip_relock96: got %b want 0", block_lock);
    else passed++;
    tick(1'b1, 2'b01);
    total++; if (block_lock !== 1'b1) $display("FAIL slip_relock97: got %b want 1", block_lock);
    else passed++;
    total++; if (slip_seen !== 5) $display("FAIL slip_extra: got %0d pulses want 5", slip_seen);
    else passed++;
  endtask

  task automatic test_loss_65();
    for (int i = 1; i <= 65; i++) begin
      tick(1'b1, 2'b11);
      if (i == 64) begin
        total++; if (block_lock !== 1'b1) $display("FAIL loss_64: got %b want 1", block_lock);
        else passed++;
        total++; if (hi_ber !== 1'b1) $display("FAIL loss_hiber: got %b want 1", hi_ber);
        else passed++;
      end
      if (i < 65) tick(1'b0, 2'b01);
    end
    total++; if (block_lock !== 1'b0) $display("FAIL loss_65: got %b want 0", block_lock);
    else passed++;
    total++; if (hi_ber !== 1'b0) $display("FAIL loss_hiber0: got %b want 0", hi_ber);
    else passed++;
    total++; if (link_up !== 1'b0) $display("FAIL loss_link: got %b want 0", link_up);
    else passed++;
    total++; if (slip !== 1'b1) $display("FAIL loss_slip: got %b want 1", slip); else passed++;
    total++; if (slip_cnt !== 16'd6) $display("FAIL loss_slipcnt: got %0d want 6", slip_cnt);
    else passed++;
    tick(1'b0, 2'b01);
    total++; if (slip !== 1'b0) $display("FAIL loss_slip1cyc: got %b want 0", slip);
    else passed++;
  endtask

  task automatic test_hold_64();
    for (int i = 0; i < 96; i++) tick(1'b1, 2'b01);
    total++; if (block_lock !== 1'b1) $display("FAIL hold_relock: got %b want 1", block_lock);
    else passed++;
    for (int i = 0; i < 64; i++) begin
      tick(1'b1, 2'b11);
      tick(1'b0, 2'b01);
    end
    total++; if (block_lock !== 1'b1) $display("FAIL hold_64bad: got %b want 1", block_lock);
    else passed++;
    for (int i = 0; i < 960; i++) begin
      tick(1'b1, 2'b01);
      tick(1'b0, 2'b01);
    end
    total++; if (block_lock !== 1'b1) $display("FAIL hold_1024: got %b want 1", block_lock);
    else passed++;
    for (int i = 0; i < 64; i++) begin
      tick(1'b1, 2'b00);
      tick(1'b0, 2'b01);
    end
    total++; if (block_lock !== 1'b1) $display("FAIL hold_newwin: got %b want 1", block_lock);
    else passed++;
    tick(1'b1, 2'b11);
    total++; if (block_lock !== 1'b0) $display("FAIL hold_65th: got %b want 0", block_lock);
    else passed++;
    total++; if (slip_cnt !== 16'd7) $display("FAIL hold_slipcnt: got %0d want 7", slip_cnt);
    else passed++;
  endtask

  task automatic test_ber();
    relock();
    total++; if (block_lock !== 1'b1) $display("FAIL ber_relock: got %b want 1", block_lock);
    else passed++;
    run_to(1200, 1, 0, -1);
    total++; if (link_up !== 1'b1 || hi_ber !== 1'b0)
      $display("FAIL ber_start: got link %b hi_ber %b want 1 0", link_up, hi_ber);
    else passed++;
    run_to(1229, 1201, 1231, -1);
    total++; if (hi_ber !== 1'b0) $display("FAIL ber_15: got %b want 0", hi_ber); else passed++;
    run_to(1231, 1201, 1231, -1);
    total++; if (hi_ber !== 1'b1) $display("FAIL ber_16: got %b want 1", hi_ber); else passed++;
    total++; if (link_up !== 1'b0) $display("FAIL ber_link: got %b want 0", link_up);
    else passed++;
    run_to(1400, 1201, 1231, -1);
    total++; if (hi_ber !== 1'b1) $display("FAIL ber_keep: got %b want 1", hi_ber); else passed++;
    run_to(1599, 1, 0, -1);
    total++; if (hi_ber !== 1'b1) $display("FAIL ber_1599: got %b want 1", hi_ber); else passed++;
    run_to(1600, 1, 0, -1);
    total++; if (hi_ber !== 1'b0) $display("FAIL ber_clear: got %b want 0", hi_ber); else passed++;
    run_to(2623, 1, 0, -1);
    total++; if (link_up !== 1'b0) $display("FAIL ber_link2623: got %b want 0", link_up);
    else passed++;
    run_to(2624, 1, 0, -1);
    total++; if (link_up !== 1'b1) $display("FAIL ber_link2624: got %b want 1", link_up);
    else passed++;
  endtask

  task automatic test_ber_wrap();
    run_to(2799, 2771, 2799, -1);
    total++; if (hi_ber !== 1'b0) $display("FAIL wrap_old15: got %b want 0", hi_ber);
    else passed++;
    run_to(2800, 1, 0, 2800);
    total++; if (hi_ber !== 1'b0) $display("FAIL wrap_end: got %b want 0", hi_ber); else passed++;
    run_to(2827, 2801, 2829, -1);
    total++; if (hi_ber !== 1'b0) $display("FAIL wrap_new15: got %b want 0", hi_ber);
    else passed++;
    run_to(2829, 2801, 2829, -1);
    total++; if (hi_ber !== 1'b1) $display("FAIL wrap_new16: got %b want 1", hi_ber);
    else passed++;
    total++; if (block_lock !== 1'b1) $display("FAIL wrap_lock: got %b want 1", block_lock);
    else passed++;
  endtask

  task automatic test_enable();
    enable = 1'b0;
    tick(1'b0, 2'b01);
    total++; if (block_lock !== 1'b0 || hi_ber !== 1'b0 || link_up !== 1'b0)
      $display("FAIL en_locked: got lock %b hi_ber %b link %b want 0 0 0",
               block_lock, hi_ber, link_up);
    else passed++;
    total++; if (slip_cnt !== 16'd0) $display("FAIL en_slipcnt: got %0d want 0", slip_cnt);
    else passed++;
    enable = 1'b1;
    tick(1'b0, 2'b01);
    tick(1'b1, 2'b11);
    total++; if (slip !== 1'b1 || slip_cnt !== 16'd1)
      $display("FAIL en_slip: got slip %b cnt %0d want 1 1", slip, slip_cnt);
    else passed++;
    repeat (5) tick(1'b0, 2'b01);
    enable = 1'b0;
    tick(1'b0, 2'b01);
    total++; if (slip_cnt !== 16'd0 || slip !== 1'b0)
      $display("FAIL en_wait: got slip %b cnt %0d want 0 0", slip, slip_cnt);
    else passed++;
    enable = 1'b1;
    tick(1'b0, 2'b01);
    for (int i = 0; i < 63; i++) tick(1'b1, 2'b01);
    total++; if (block_lock !== 1'b0) $display("FAIL en_restart63: got %b want 0", block_lock);
    else passed++;
    tick(1'b1, 2'b01);
    total++; if (block_lock !== 1'b1) $display("FAIL en_restart64: got %b want 1", block_lock);
    else passed++;
    enable = 1'b0;
    tick(1'b0, 2'b01);
    enable = 1'b1;
    tick(1'b0, 2'b01);
    tick(1'b1, 2'b11);
    relock();
    total++; if (block_lock !== 1'b1 || slip_cnt !== 16'd1)
      $display("FAIL arst_pre: got lock %b cnt %0d want 1 1", block_lock, slip_cnt);
    else passed++;
    repeat (10) tick(1'b1, 2'b01);
    #3;
    rst_156 = 1'b0;
    #1;
    total++; if (block_lock !== 1'b0 || slip_cnt !== 16'd0 || hi_ber !== 1'b0 ||
                 link_up !== 1'b0 || slip !== 1'b0)
      $display("FAIL arst_async: got lock %b cnt %0d hi_ber %b link %b slip %b want all 0",
               block_lock, slip_cnt, hi_ber, link_up, slip);
    else passed++;
    tick(1'b0, 2'b01);
    rst_156 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_slip();
    test_loss_65();
    test_hold_64();
    test_ber();
    test_ber_wrap();
    test_enable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
